hlsm_avg_n: RTL

Parametrised multi-cycle averaging datapath with a Start/Done handshake. It sums N_IN operands with a single shared adder, then applies SHIFT_STAGES right shifts by `sa` to produce `avg`. It replaces the fixed 8-input, 32-bit, unsigned HLSM averager with one that:
- captures its operands at Start,
- accumulates without overflow,
- supports signed data,
- rejects new requests while busy.

---
 rtl/hlsm_avg_pkg.sv | 25 ++
 rtl/hlsm_avg_n.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hlsm_avg_pkg.sv
// hlsm_avg_pkg
// Shared definitions for the hlsm_avg_n multi-cycle averager:
//   - state_e   : FSM state encoding (2 bits)
//   - acc_width : accumulator width needed to sum n_in operands of width bits
//   - cnt_width : width of a counter that must reach n-1 (minimum 1 bit)
package hlsm_avg_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcc   = 2'd1,
    StShift = 2'd2,
    StFinal = 2'd3
  } state_e;

  // Headroom of clog2(n_in) bits keeps n_in full-scale operands from wrapping,
  // for both unsigned and two's-complement data.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned n_in);
    return width + $clog2(n_in);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hlsm_avg_n.sv
// hlsm_avg_n
// Multi-cycle averager: on Start the operands, shift amount and mode are
// captured, summed one per cycle through a single adder into a widened
// accumulator, right-shifted SHIFT_STAGES times by sa, then truncated to WIDTH.
//
// Ports:
//   Clk         in   clock, rising edge
//   Rst         in   asynchronous reset, active low
//   Start       in   request, only sampled while idle
//   signed_mode in   1: two's-complement operands / arithmetic shifts
//                    0: unsigned operands / logical shifts
//   din         in   N_IN packed operands, operand i at din[i*WIDTH +: WIDTH]
//   sa          in   shift amount applied at every shift stage
//   Busy        out  high whenever an operation is in progress
//   Done        out  one-cycle completion pulse
//   avg         out  result, held until the next completion
module hlsm_avg_n
  import hlsm_avg_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned N_IN         = 8,
  parameter int unsigned SHIFT_STAGES = 3,
  parameter int unsigned SA_W         = 6
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   signed_mode,
  input  logic [N_IN*WIDTH-1:0]  din,
  input  logic [SA_W-1:0]        sa,
  output logic                   Busy,
  output logic                   Done,
  output logic [WIDTH-1:0]       avg
);

  localparam int unsigned ACC_W = acc_width(WIDTH, N_IN);
  localparam int unsigned EXT_W = ACC_W - WIDTH;
  localparam int unsigned IDX_W = cnt_width(N_IN);
  localparam int unsigned SH_W  = cnt_width(SHIFT_STAGES);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_IN - 1);
  localparam logic [SH_W-1:0]  ShLast  = SH_W'((SHIFT_STAGES == 0) ? 0 : SHIFT_STAGES - 1);

  if (N_IN < 2) begin : gen_bad_n_in
    $error("hlsm_avg_n: N_IN must be at least 2");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  ops_q [N_IN];
  logic [SA_W-1:0]   sa_q;
  logic              mode_q;
  logic [ACC_W-1:0]  acc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SH_W-1:0]   sh_q;

  logic [WIDTH-1:0]  op_sel;
  logic [ACC_W-1:0]  op_ext;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_shr;
  logic              sa_big;

  // Shared adder and shifter, both controlled by the captured mode.
  always_comb begin
    op_sel  = ops_q[idx_q];
    op_ext  = mode_q ? {{EXT_W{op_sel[WIDTH-1]}}, op_sel} : {{EXT_W{1'b0}}, op_sel};
    acc_sum = acc_q + op_ext;

    // Oversized shifts are resolved explicitly so the result is all sign bits
    // (signed) or zero (unsigned) regardless of how the shifter treats them.
    sa_big = (32'(sa_q) >= 32'(ACC_W));
    if (sa_big) begin
      acc_shr = (mode_q && acc_q[ACC_W-1]) ? '1 : '0;
    end else if (mode_q) begin
      acc_shr = $unsigned($signed(acc_q) >>> sa_q);
    end else begin
      acc_shr = acc_q >> sa_q;
    end
  end

  always_comb begin
    Busy = (state_q != StIdle);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(N_IN); i++) begin
        ops_q[i] <= '0;
      end
      sa_q   <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      Done   <= 1'b0;
      avg    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          Done <= 1'b0;
          if (Start) begin
            for (int i = 0; i < int'(N_IN); i++) begin
              ops_q[i] <= din[i*WIDTH +: WIDTH];
            end
            sa_q    <= sa;
            mode_q  <= signed_mode;
            acc_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            state_q <= StAcc;
          end
        end

        StAcc: begin
          acc_q <= acc_sum;
          if (idx_q == IdxLast) begin
            idx_q   <= '0;
            state_q <= (SHIFT_STAGES == 0) ? StFinal : StShift;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        StShift: begin
          acc_q <= acc_shr;
          if (sh_q == ShLast) begin
            sh_q    <= '0;
            state_q <= StFinal;
          end else begin
            sh_q <= sh_q + SH_W'(1);
          end
        end

        StFinal: begin
          avg     <= acc_q[WIDTH-1:0];
          Done    <= 1'b1;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
